switch_led_ctrl: RTL

Parametrised N-channel switch/button-to-LED controller for the board I/O lab designs. It synchronises N slide switches and debounces one push-button. It then drives N registered LEDs in one of four run-time modes: direct, latch, toggle or blink. It sits directly between board pins and LEDs and replaces the plain combinational switch-AND-not-button gating.

---
 rtl/switch_led_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/switch_led_ctrl.sv
// N switches + one debounced button drive N registered LEDs (direct/latch/toggle/blink).
// Switch-to-LED latency 3 cycles; button press seen 2+DEBOUNCE_CYCLES cycles after rise; no stalls, no backpressure.
module switch_led_ctrl #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLINK_HALF      = 12500000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic         boton,
    input  logic [1:0]   mode,
    output logic [N-1:0] led,
    output logic         pressed
);

    typedef enum logic [1:0] {
        M_DIRECT = 2'd0,
        M_LATCH  = 2'd1,
        M_TOGGLE = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_HALF - 1);

    logic [N-1:0]  sw_m, sw_s;
    logic          btn_m, btn_s;
    logic          btn_db;
    logic [DW-1:0] dcnt;
    logic [BW-1:0] bcnt;
    logic          phase;
    logic [N-1:0]  snap, tog;
    logic [N-1:0]  snap_nxt, tog_nxt, led_nxt;
    mode_t         mode_q;

    assign mode_q = mode_t'(mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_m  <= '0;
            sw_s  <= '0;
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sw_m  <= sw;
            sw_s  <= sw_m;
            btn_m <= boton;
            btn_s <= btn_m;
        end
    end

    // pressed is raised on the same edge btn_db goes high, so both read 1 together.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db  <= 1'b0;
            dcnt    <= '0;
            pressed <= 1'b0;
        end else begin
            pressed <= 1'b0;
            if (btn_s != btn_db) begin
                if (dcnt == DLAST) begin
                    btn_db  <= btn_s;
                    dcnt    <= '0;
                    pressed <= btn_s;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end else begin
                dcnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BLAST) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    // Stores only move in their own mode, so leaving and returning restores the pattern.
    always_comb begin
        snap_nxt = snap;
        tog_nxt  = tog;
        led_nxt  = '0;
        if (pressed && mode_q == M_LATCH)  snap_nxt = sw_s;
        if (pressed && mode_q == M_TOGGLE) tog_nxt  = tog ^ sw_s;
        case (mode_q)
            M_DIRECT: led_nxt = sw_s & ~{N{btn_db}};
            M_LATCH:  led_nxt = snap_nxt;
            M_TOGGLE: led_nxt = tog_nxt;
            M_BLINK:  led_nxt = sw_s & {N{phase}} & ~{N{btn_db}};
            default:  led_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
            tog  <= '0;
            led  <= '0;
        end else begin
            snap <= snap_nxt;
            tog  <= tog_nxt;
            led  <= led_nxt;
        end
    end

endmodule
